// File: rtl/counter24_if.sv
// ============================================================================
//  Module   : counter24_if
//  Brief    : Key-pulse inputs and display-side outputs of the 00-23 controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface counter24_if;
  logic       key_mode;
  logic       key_run;
  logic       key_inc;
  logic [7:0] result;
  logic       disp_en;
  logic       carry_out;
  logic [1:0] mode_out;

  modport master (
    output key_mode, key_run, key_inc,
    input  result, disp_en, carry_out, mode_out
  );

  modport slave (
    input  key_mode, key_run, key_inc,
    output result, disp_en, carry_out, mode_out
  );
endinterface

`default_nettype wire

// File: rtl/counter24_ctrl.sv
// ============================================================================
//  Module   : counter24_ctrl
//  Brief    : RUN/PAUSE/SET controller for a 00-23 BCD counter with prescaler,
//             SET-mode display blinking and a day-wrap carry pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter24_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  counter24_if.slave bus
);

  localparam int C_PW = $clog2(TICK_DIV);
  localparam int C_BW = $clog2(BLINK_DIV);

  // State codes double as the Mode_Out encoding.
  localparam logic [1:0] c_st_run   = 2'b00;
  localparam logic [1:0] c_st_pause = 2'b01;
  localparam logic [1:0] c_st_set   = 2'b10;

  localparam logic [C_PW-1:0] c_tick_last  = C_PW'(TICK_DIV - 1);
  localparam logic [C_BW-1:0] c_blink_last = C_BW'(BLINK_DIV - 1);

  logic [1:0]      state_q,    state_d;
  logic [7:0]      result_q,   result_d;
  logic            carry_q,    carry_d;
  logic            disp_en_q,  disp_en_d;
  logic [C_PW-1:0] prescale_q, prescale_d;
  logic [C_BW-1:0] blink_q,    blink_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk) begin : p_state_reg
    if (rst) begin
      state_q    <= c_st_pause;
      result_q   <= 8'h00;
      carry_q    <= 1'b0;
      disp_en_q  <= 1'b1;
      prescale_q <= '0;
      blink_q    <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      disp_en_q  <= disp_en_d;
      prescale_q <= prescale_d;
      blink_q    <= blink_d;
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    if (bus.key_mode)
      state_d = (state_q == c_st_set) ? c_st_pause : c_st_set;
    else if (bus.key_run)
      state_d = (state_q == c_st_run) ? c_st_pause : c_st_run;
  end

  // Any mode change leaves counters at 0 and the display on, which also
  // gives the clean entry conditions for both RUN and SET.
  always_comb begin : p_outputs
    result_d   = result_q;
    carry_d    = 1'b0;
    disp_en_d  = 1'b1;
    prescale_d = '0;
    blink_d    = '0;
    if (!bus.key_mode && !bus.key_run) begin
      case (state_q)
        c_st_run: begin
          if (prescale_q == c_tick_last) begin
            result_d = bcd_inc(result_q);
            carry_d  = (result_q == 8'h23);
          end else begin
            prescale_d = prescale_q + C_PW'(1);
          end
        end
        c_st_set: begin
          if (bus.key_inc) begin
            result_d = bcd_inc(result_q);
          end else if (blink_q == c_blink_last) begin
            disp_en_d = ~disp_en_q;
          end else begin
            blink_d   = blink_q + C_BW'(1);
            disp_en_d = disp_en_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.disp_en   = disp_en_q;
  assign bus.mode_out  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_counter24_ctrl.sv
// ============================================================================
//  Module   : tb_counter24_ctrl
//  Brief    : Directed scenarios plus random key traffic against a counting model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter24_ctrl;

  localparam int TICK  = 4;
  localparam int BLINK = 3;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  counter24_if bus();

  counter24_ctrl #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: mode 0=RUN 1=PAUSE 2=SET, value as plain hours 0..23, and
  // elapsed-cycle counts since entering RUN / last blink restart.
  int   m_mode;
  int   m_val;
  int   m_run_cyc;
  int   m_blink_cyc;
  bit   m_carry;
  bit   m_valid;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic bit exp_disp();
    return (m_mode != 2) || (((m_blink_cyc / BLINK) % 2) == 0);
  endfunction

  initial begin
    m_valid = 1'b0;
    m_mode = 1; m_val = 0; m_run_cyc = 0; m_blink_cyc = 0; m_carry = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_mode = 1; m_val = 0; m_run_cyc = 0; m_blink_cyc = 0; m_carry = 1'b0;
    end else begin
      m_carry = 1'b0;
      if (bus.key_mode) begin
        m_mode = (m_mode == 2) ? 1 : 2;
        m_run_cyc = 0; m_blink_cyc = 0;
      end else if (bus.key_run) begin
        m_mode = (m_mode == 0) ? 1 : 0;
        m_run_cyc = 0; m_blink_cyc = 0;
      end else if (m_mode == 0) begin
        m_run_cyc++;
        if (m_run_cyc % TICK == 0) begin
          m_carry = (m_val == 23);
          m_val = (m_val + 1) % 24;
        end
      end else if (m_mode == 2) begin
        if (bus.key_inc) begin
          m_val = (m_val + 1) % 24;
          m_blink_cyc = 0;
        end else begin
          m_blink_cyc++;
        end
      end
    end
    #1;
    if (m_valid) begin
      vectors++;
      if (bus.result !== to_bcd(m_val)) begin
        miscompares++;
        $display("FAIL model_result t=%0t got=%h exp=%h", $time, bus.result, to_bcd(m_val));
      end
      if (bus.mode_out !== 2'(m_mode)) begin
        miscompares++;
        $display("FAIL model_mode t=%0t got=%b exp=%b", $time, bus.mode_out, 2'(m_mode));
      end
      if (bus.disp_en !== exp_disp()) begin
        miscompares++;
        $display("FAIL model_disp t=%0t got=%b exp=%b", $time, bus.disp_en, exp_disp());
      end
      if (bus.carry_out !== m_carry) begin
        miscompares++;
        $display("FAIL model_carry t=%0t got=%b exp=%b", $time, bus.carry_out, m_carry);
      end
    end
  end

  // Drive one cycle of inputs, then return just after the edge that sampled them.
  task automatic step(input bit m, input bit r, input bit i, input bit rs);
    @(negedge clk);
    bus.key_mode = m; bus.key_run = r; bus.key_inc = i; rst = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic preset(input int v);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int k = 0; k < v; k++) step(0, 0, 1, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0;
    bus.key_mode = 1'b0; bus.key_run = 1'b0; bus.key_inc = 1'b0;

    // Reset values
    step(0, 0, 0, 1);
    check("rst_result", bus.result, 8'h00);
    check("rst_mode", 8'(bus.mode_out), 8'h01);
    check("rst_disp", 8'(bus.disp_en), 8'h01);
    check("rst_carry", 8'(bus.carry_out), 8'h00);

    // Run from reset: increments 4, 8, 12 cycles after the key
    step(0, 1, 0, 0);
    check("run_mode", 8'(bus.mode_out), 8'h00);
    idle(3);
    check("run_pre_tick", bus.result, 8'h00);
    idle(1);
    check("run_tick1", bus.result, 8'h01);
    idle(4);
    check("run_tick2", bus.result, 8'h02);
    idle(4);
    check("run_tick3", bus.result, 8'h03);
    check("run_nocarry", 8'(bus.carry_out), 8'h00);

    // Preset 22, run through the day wrap
    preset(22);
    step(0, 1, 0, 0);
    idle(4);
    check("wrap_23", bus.result, 8'h23);
    idle(4);
    check("wrap_00", bus.result, 8'h00);
    check("wrap_carry", 8'(bus.carry_out), 8'h01);
    idle(1);
    check("wrap_carry_end", 8'(bus.carry_out), 8'h00);

    // SET wrap by Key_Inc, then blinking
    preset(23);
    check("set_23", bus.result, 8'h23);
    step(0, 0, 1, 0);
    check("set_inc_wrap", bus.result, 8'h00);
    check("set_inc_nocarry", 8'(bus.carry_out), 8'h00);
    check("set_inc_disp", 8'(bus.disp_en), 8'h01);
    idle(2);
    check("blink_hold", 8'(bus.disp_en), 8'h01);
    idle(1);
    check("blink_off", 8'(bus.disp_en), 8'h00);
    idle(3);
    check("blink_on", 8'(bus.disp_en), 8'h01);

    // Key_Run collides with the tick
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(3);
    step(0, 1, 0, 0);
    check("collide_mode", 8'(bus.mode_out), 8'h01);
    check("collide_result", bus.result, 8'h00);
    step(0, 1, 0, 0);
    idle(3);
    check("restart_pre", bus.result, 8'h00);
    idle(1);
    check("restart_tick", bus.result, 8'h01);

    // Key priority
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    check("prio_set", 8'(bus.mode_out), 8'h02);
    check("prio_set_val", bus.result, 8'h00);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    check("prio_pause", 8'(bus.mode_out), 8'h01);
    check("prio_pause_val", bus.result, 8'h01);

    // Reset in RUN mid-prescale with a key held
    preset(15);
    step(0, 1, 0, 0);
    idle(2);
    check("pre_rst_val", bus.result, 8'h15);
    step(0, 1, 0, 1);
    check("midrst_result", bus.result, 8'h00);
    check("midrst_mode", 8'(bus.mode_out), 8'h01);
    check("midrst_disp", 8'(bus.disp_en), 8'h01);
    check("midrst_carry", 8'(bus.carry_out), 8'h00);

    // Random key traffic, checked each cycle by the model
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
    end
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter24_ctrl.md
# counter24_ctrl

Run/pause/set controller for the 0–23 BCD counter feeding the 6-digit display driver. It owns the count value and the count-rate prescaler, and sequences three modes from debounced key pulses: RUN, PAUSE and SET. It drives the BCD value, a display-enable used for blinking while setting, and a day-wrap carry pulse. It sits between the key debouncers and the display driver, in place of a free-running accumulator.

## Interface
- TICK_DIV, 50_000_000: CLK cycles per count increment in RUN; legal range ≥ 2.
- BLINK_DIV, 12_500_000: CLK cycles per display-enable half-period in SET; legal range ≥ 2.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Key_Mode  in  1  one-cycle pulse, debounced: enter or leave SET.
- Key_Run  in  1  one-cycle pulse: toggle RUN/PAUSE; from SET, go to RUN.
- Key_Inc  in  1  one-cycle pulse: +1 to the value while in SET.
- Result  out  8  BCD value: tens in [7:4] (0–2), units in [3:0] (0–9); range 00–23.
- Disp_En  out  1  1 = display on, 0 = blank; blinks in SET.
- Carry_Out  out  1  one-cycle pulse on the 23→00 wrap in RUN.
- Mode_Out  out  2  00 = RUN, 01 = PAUSE, 10 = SET; 11 is never driven.

## Operation
- FSM states: RUN, PAUSE, SET. Reset state is PAUSE.
- Key priority within one cycle: Key_Mode > Key_Run > Key_Inc. Only the highest-priority asserted key acts; the others are dropped.
- RUN:
  - Key_Mode → SET.
  - Key_Run → PAUSE.
  - Otherwise the prescaler counts 0…TICK_DIV-1. At TICK_DIV-1 the value increments and the prescaler returns to 0.
- PAUSE:
  - Key_Mode → SET.
  - Key_Run → RUN.
  - Key_Inc is ignored. The value holds.
- SET:
  - Key_Mode → PAUSE.
  - Key_Run → RUN.
  - Key_Inc → value +1.
  - The prescaler does not run.
- Prescaler is held at 0 in PAUSE and SET, so it always restarts from 0 on entry to RUN.
- BCD increment rule:
  - units 9 → units 0, tens +1.
  - 23 → 00.
  - Units above 9 and tens above 2 are unreachable.
- Carry_Out pulses only on a RUN tick wrap 23→00. A Key_Inc wrap in SET gives no carry.
- Key vs tick in the same RUN cycle: the key's transition wins and the increment is suppressed (no increment, no carry).
- Disp_En:
  - Outside SET it is 1.
  - On entry to SET: Disp_En = 1 and the blink counter = 0.
  - In SET it toggles every BLINK_DIV cycles.
  - Key_Inc in SET forces Disp_En = 1 and restarts the blink counter.

## Timing
- All outputs are registered. The effect of a key or tick is visible on the cycle after the edge that samples it.
- Reset values:
  - Result = 8'h00
  - Disp_En = 1
  - Carry_Out = 0
  - Mode_Out = 01
  - prescaler = 0
  - blink counter = 0
- RST during any state or mid-prescale overrides everything on that edge. Keys asserted together with RST are discarded.
- First increment after entering RUN happens exactly TICK_DIV cycles after the edge that sampled Key_Run (or Key_Run from SET). Later increments follow every TICK_DIV cycles.
- Carry_Out is high for exactly the one cycle in which Result first shows 00.
- First Disp_En toggle in SET happens BLINK_DIV cycles after entry.
- Key pulses longer than one cycle are out of contract. Each asserted cycle is treated as a separate press.

## Test plan
(All scenarios use TICK_DIV=4, BLINK_DIV=3.)
- Reset then Key_Run, idle 12 cycles → Mode_Out 00; Result steps 00→01→02→03 at 4, 8 and 12 cycles after the key; Carry_Out stays 0.
- Preset 22 via SET (Key_Mode, then 22× Key_Inc, then Key_Run), run 8 cycles → Result 23, then 00 with Carry_Out high for exactly that one cycle.
- In SET at 23, Key_Inc → Result 00, Carry_Out 0, Disp_En forced 1. With no keys, Disp_En toggles 1→0→1 every 3 cycles.
- Key_Run in the same cycle as the RUN tick at prescaler 3 → Mode_Out 01, Result unchanged. A later Key_Run gives the next increment 4 cycles afterwards.
- Key_Mode + Key_Run + Key_Inc together in PAUSE → SET entered, Result unchanged. In SET, Key_Mode + Key_Inc together → PAUSE, Result unchanged.
- RST asserted in RUN mid-prescale with Result 15 and Key_Run high → next cycle Result 00, Mode_Out 01, Disp_En 1, Carry_Out 0.
